// File: rtl/sc_frog_move_ctrl.sv
// sc_frog_move_ctrl
// Command initiator for the point-type frog register. Converts active-low
// button presses into one-cycle shift / respawn strobes, tracks the frog's
// row, the remaining lives and the score, and flags collisions and nest hits.
// Every strobe is a registered decode of the state it belongs to.
module sc_frog_move_ctrl #(
    parameter int FMC_DATAWIDTH  = 8,
    parameter int FMC_ROWWIDTH   = 3,
    parameter int FMC_LIVES_INIT = 3,
    parameter int FMC_SCOREWIDTH = 4
) (
    input  logic                      SC_FrogMoveCtrl_CLOCK_50,
    input  logic                      SC_FrogMoveCtrl_RESET_InHigh,
    input  logic                      SC_FrogMoveCtrl_left_InLow,
    input  logic                      SC_FrogMoveCtrl_right_InLow,
    input  logic                      SC_FrogMoveCtrl_up_InLow,
    input  logic                      SC_FrogMoveCtrl_down_InLow,
    input  logic [FMC_DATAWIDTH-1:0]  SC_FrogMoveCtrl_frog_InBUS,
    input  logic [FMC_DATAWIDTH-1:0]  SC_FrogMoveCtrl_obstacle_InBUS,
    output logic [1:0]                SC_FrogMoveCtrl_shiftselection_Out,
    output logic                      SC_FrogMoveCtrl_collision_OutLow,
    output logic                      SC_FrogMoveCtrl_nest_reached_OutLow,
    output logic                      SC_FrogMoveCtrl_frog_reset_OutLow,
    output logic                      SC_FrogMoveCtrl_clear_OutLow,
    output logic [FMC_ROWWIDTH-1:0]   SC_FrogMoveCtrl_row_OutBUS,
    output logic [1:0]                SC_FrogMoveCtrl_lives_OutBUS,
    output logic [FMC_SCOREWIDTH-1:0] SC_FrogMoveCtrl_score_OutBUS
);

    typedef enum logic [2:0] {
        SPAWN,
        IDLE,
        SHL,
        SHR,
        CHECK,
        COLLIDE,
        NEST,
        GAMEOVER
    } state_t;

    localparam logic [FMC_ROWWIDTH-1:0]   NEST_ROW   = '1;
    localparam logic [FMC_ROWWIDTH-1:0]   ROW_ONE    = 1;
    localparam logic [FMC_ROWWIDTH-1:0]   ROW_ZERO   = '0;
    localparam logic [FMC_SCOREWIDTH-1:0] SCORE_MAX  = '1;
    localparam logic [FMC_SCOREWIDTH-1:0] SCORE_ONE  = 1;
    localparam logic [1:0]                LIVES_INIT = 2'(FMC_LIVES_INIT);

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;

    state_t state;

    logic left_prev;
    logic right_prev;
    logic up_prev;
    logic down_prev;

    logic press_left;
    logic press_right;
    logic press_up;
    logic press_down;
    logic overlap;

    // A press is the cycle where the button is low but was high one clock ago,
    // so holding a button never produces a second command.
    assign press_left  = left_prev  & ~SC_FrogMoveCtrl_left_InLow;
    assign press_right = right_prev & ~SC_FrogMoveCtrl_right_InLow;
    assign press_up    = up_prev    & ~SC_FrogMoveCtrl_up_InLow;
    assign press_down  = down_prev  & ~SC_FrogMoveCtrl_down_InLow;

    assign overlap = |(SC_FrogMoveCtrl_frog_InBUS & SC_FrogMoveCtrl_obstacle_InBUS);

    // Previous button levels for falling-edge detection (released after reset).
    always_ff @(posedge SC_FrogMoveCtrl_CLOCK_50) begin
        if (SC_FrogMoveCtrl_RESET_InHigh) begin
            left_prev  <= 1'b1;
            right_prev <= 1'b1;
            up_prev    <= 1'b1;
            down_prev  <= 1'b1;
        end else begin
            left_prev  <= SC_FrogMoveCtrl_left_InLow;
            right_prev <= SC_FrogMoveCtrl_right_InLow;
            up_prev    <= SC_FrogMoveCtrl_up_InLow;
            down_prev  <= SC_FrogMoveCtrl_down_InLow;
        end
    end

    // Game FSM with counters; each strobe is set on entry to its state and
    // falls back to inactive by default, giving clean one-cycle pulses.
    always_ff @(posedge SC_FrogMoveCtrl_CLOCK_50) begin
        if (SC_FrogMoveCtrl_RESET_InHigh) begin
            state                               <= SPAWN;
            SC_FrogMoveCtrl_row_OutBUS          <= ROW_ZERO;
            SC_FrogMoveCtrl_lives_OutBUS        <= LIVES_INIT;
            SC_FrogMoveCtrl_score_OutBUS        <= '0;
            SC_FrogMoveCtrl_shiftselection_Out  <= SEL_HOLD;
            SC_FrogMoveCtrl_collision_OutLow    <= 1'b1;
            SC_FrogMoveCtrl_nest_reached_OutLow <= 1'b1;
            SC_FrogMoveCtrl_frog_reset_OutLow   <= 1'b0;
            SC_FrogMoveCtrl_clear_OutLow        <= 1'b1;
        end else begin
            SC_FrogMoveCtrl_shiftselection_Out  <= SEL_HOLD;
            SC_FrogMoveCtrl_collision_OutLow    <= 1'b1;
            SC_FrogMoveCtrl_nest_reached_OutLow <= 1'b1;
            SC_FrogMoveCtrl_frog_reset_OutLow   <= 1'b1;
            SC_FrogMoveCtrl_clear_OutLow        <= 1'b1;

            case (state)
                SPAWN: begin
                    SC_FrogMoveCtrl_row_OutBUS <= ROW_ZERO;
                    state                      <= IDLE;
                end

                IDLE: begin
                    // A moving obstacle hitting a still frog outranks any press.
                    if (overlap) begin
                        state                            <= COLLIDE;
                        SC_FrogMoveCtrl_collision_OutLow <= 1'b0;
                    end else if (press_up) begin
                        SC_FrogMoveCtrl_row_OutBUS <= SC_FrogMoveCtrl_row_OutBUS + ROW_ONE;
                        state                      <= CHECK;
                    end else if (press_down) begin
                        if (SC_FrogMoveCtrl_row_OutBUS != ROW_ZERO) begin
                            SC_FrogMoveCtrl_row_OutBUS <= SC_FrogMoveCtrl_row_OutBUS - ROW_ONE;
                            state                      <= CHECK;
                        end
                    end else if (press_left) begin
                        if (!SC_FrogMoveCtrl_frog_InBUS[FMC_DATAWIDTH-1]) begin
                            state                              <= SHL;
                            SC_FrogMoveCtrl_shiftselection_Out <= SEL_LEFT;
                        end
                    end else if (press_right) begin
                        if (!SC_FrogMoveCtrl_frog_InBUS[0]) begin
                            state                              <= SHR;
                            SC_FrogMoveCtrl_shiftselection_Out <= SEL_RIGHT;
                        end
                    end
                end

                SHL, SHR: begin
                    state <= CHECK;
                end

                CHECK: begin
                    if (overlap) begin
                        state                            <= COLLIDE;
                        SC_FrogMoveCtrl_collision_OutLow <= 1'b0;
                    end else if (SC_FrogMoveCtrl_row_OutBUS == NEST_ROW) begin
                        state                               <= NEST;
                        SC_FrogMoveCtrl_nest_reached_OutLow <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                COLLIDE: begin
                    SC_FrogMoveCtrl_lives_OutBUS <= SC_FrogMoveCtrl_lives_OutBUS - 2'd1;
                    if (SC_FrogMoveCtrl_lives_OutBUS == 2'd1) begin
                        state                        <= GAMEOVER;
                        SC_FrogMoveCtrl_clear_OutLow <= 1'b0;
                    end else begin
                        state                             <= SPAWN;
                        SC_FrogMoveCtrl_frog_reset_OutLow <= 1'b0;
                    end
                end

                NEST: begin
                    if (SC_FrogMoveCtrl_score_OutBUS != SCORE_MAX) begin
                        SC_FrogMoveCtrl_score_OutBUS <= SC_FrogMoveCtrl_score_OutBUS + SCORE_ONE;
                    end
                    state                             <= SPAWN;
                    SC_FrogMoveCtrl_frog_reset_OutLow <= 1'b0;
                end

                GAMEOVER: begin
                    SC_FrogMoveCtrl_lives_OutBUS <= 2'd0;
                    SC_FrogMoveCtrl_clear_OutLow <= 1'b0;
                    state                        <= GAMEOVER;
                end

                default: begin
                    state                             <= SPAWN;
                    SC_FrogMoveCtrl_frog_reset_OutLow <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_frog_move_ctrl.sv
// Directed bench for sc_frog_move_ctrl. The frog and obstacle buses are
// driven straight from the bench; expected values are worked out by hand.
module tb_sc_frog_move_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       left_n, right_n, up_n, down_n;
    logic [7:0] frog, obst;
    logic [1:0] shiftsel;
    logic       collision_n, nest_n, frog_reset_n, clear_n;
    logic [2:0] row;
    logic [1:0] lives;
    logic [3:0] score;

    int nvec  = 0;
    int nmiss = 0;
    int cnt;

    sc_frog_move_ctrl dut (
        .SC_FrogMoveCtrl_CLOCK_50            (clk),
        .SC_FrogMoveCtrl_RESET_InHigh        (rst),
        .SC_FrogMoveCtrl_left_InLow          (left_n),
        .SC_FrogMoveCtrl_right_InLow         (right_n),
        .SC_FrogMoveCtrl_up_InLow            (up_n),
        .SC_FrogMoveCtrl_down_InLow          (down_n),
        .SC_FrogMoveCtrl_frog_InBUS          (frog),
        .SC_FrogMoveCtrl_obstacle_InBUS      (obst),
        .SC_FrogMoveCtrl_shiftselection_Out  (shiftsel),
        .SC_FrogMoveCtrl_collision_OutLow    (collision_n),
        .SC_FrogMoveCtrl_nest_reached_OutLow (nest_n),
        .SC_FrogMoveCtrl_frog_reset_OutLow   (frog_reset_n),
        .SC_FrogMoveCtrl_clear_OutLow        (clear_n),
        .SC_FrogMoveCtrl_row_OutBUS          (row),
        .SC_FrogMoveCtrl_lives_OutBUS        (lives),
        .SC_FrogMoveCtrl_score_OutBUS        (score)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean up press followed by a release cycle.
    task automatic press_up();
        up_n = 1'b0;
        tick();
        up_n = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        left_n = 1'b1; right_n = 1'b1; up_n = 1'b1; down_n = 1'b1;
        frog = 8'h10;
        obst = 8'h00;

        // T1: reset values and the single respawn cycle after release
        repeat (3) tick();
        check_vec("rst_frog_reset", 32'(frog_reset_n), 32'd0);
        check_vec("rst_row",        32'(row),          32'd0);
        check_vec("rst_lives",      32'(lives),        32'd3);
        check_vec("rst_score",      32'(score),        32'd0);
        check_vec("rst_shiftsel",   32'(shiftsel),     32'd0);
        check_vec("rst_collision",  32'(collision_n),  32'd1);
        check_vec("rst_nest",       32'(nest_n),       32'd1);
        check_vec("rst_clear",      32'(clear_n),      32'd1);
        rst = 1'b0;
        #3;
        check_vec("spawn_pulse_low", 32'(frog_reset_n), 32'd0);
        tick();
        check_vec("spawn_pulse_end", 32'(frog_reset_n), 32'd1);
        tick();
        check_vec("spawn_stays_hi",  32'(frog_reset_n), 32'd1);

        // T2: holding left gives exactly one rotate-left cycle
        left_n = 1'b0;
        tick();
        check_vec("t2_shl", 32'(shiftsel), 32'd1);
        tick();
        check_vec("t2_after_shl", 32'(shiftsel), 32'd0);
        cnt = 0;
        repeat (8) begin
            tick();
            if (shiftsel != 2'b00) cnt++;
        end
        check_vec("t2_hold_no_repeat", 32'(cnt), 32'd0);
        left_n = 1'b1;
        tick();

        // T3: edge-blocked shifts, then a legal shift proves we are back in IDLE
        frog = 8'h80;
        left_n = 1'b0;
        cnt = 0;
        repeat (3) begin
            tick();
            if (shiftsel != 2'b00) cnt++;
        end
        check_vec("t3_left_blocked", 32'(cnt), 32'd0);
        left_n = 1'b1;
        tick();
        frog = 8'h01;
        right_n = 1'b0;
        cnt = 0;
        repeat (3) begin
            tick();
            if (shiftsel != 2'b00) cnt++;
        end
        check_vec("t3_right_blocked", 32'(cnt), 32'd0);
        right_n = 1'b1;
        tick();
        left_n = 1'b0;
        tick();
        check_vec("t3_left_ok", 32'(shiftsel), 32'd1);
        left_n = 1'b1;
        tick();
        tick();

        // T4: down at row 0 ignored; up beats left; down from row 1
        frog = 8'h10;
        down_n = 1'b0;
        tick();
        tick();
        check_vec("t4_down_row0", 32'(row), 32'd0);
        down_n = 1'b1;
        tick();
        up_n = 1'b0;
        left_n = 1'b0;
        tick();
        check_vec("t4_up_row", 32'(row), 32'd1);
        check_vec("t4_up_noshift", 32'(shiftsel), 32'd0);
        tick();
        check_vec("t4_left_dropped", 32'(shiftsel), 32'd0);
        up_n = 1'b1;
        left_n = 1'b1;
        tick();
        down_n = 1'b0;
        tick();
        check_vec("t4_down_row", 32'(row), 32'd0);
        down_n = 1'b1;
        tick();
        tick();

        // T5: collisions down to GAMEOVER, then reset recovery
        press_up();
        check_vec("t5_row1", 32'(row), 32'd1);
        obst = 8'h10;
        tick();
        check_vec("t5_collision", 32'(collision_n), 32'd0);
        check_vec("t5_lives_hold", 32'(lives), 32'd3);
        obst = 8'h00;
        tick();
        check_vec("t5_lives2", 32'(lives), 32'd2);
        check_vec("t5_respawn", 32'(frog_reset_n), 32'd0);
        check_vec("t5_coll_end", 32'(collision_n), 32'd1);
        tick();
        check_vec("t5_row_reset", 32'(row), 32'd0);
        check_vec("t5_respawn_end", 32'(frog_reset_n), 32'd1);
        obst = 8'h10;
        tick();
        obst = 8'h00;
        tick();
        tick();
        check_vec("t5_lives1", 32'(lives), 32'd1);
        obst = 8'h10;
        tick();
        tick();
        check_vec("t5_gameover_clear", 32'(clear_n), 32'd0);
        check_vec("t5_gameover_lives", 32'(lives), 32'd0);
        up_n = 1'b0;
        left_n = 1'b0;
        repeat (4) tick();
        check_vec("t5_go_row", 32'(row), 32'd0);
        check_vec("t5_go_clear_held", 32'(clear_n), 32'd0);
        check_vec("t5_go_noshift", 32'(shiftsel), 32'd0);
        check_vec("t5_go_no_respawn", 32'(frog_reset_n), 32'd1);
        up_n = 1'b1;
        left_n = 1'b1;
        rst = 1'b1;
        tick();
        check_vec("t5_rst_lives", 32'(lives), 32'd3);
        check_vec("t5_rst_clear", 32'(clear_n), 32'd1);
        rst = 1'b0;
        obst = 8'h00;
        tick();

        // T6: seven ups reach the nest
        repeat (6) press_up();
        check_vec("t6_row6", 32'(row), 32'd6);
        up_n = 1'b0;
        tick();
        check_vec("t6_row7", 32'(row), 32'd7);
        up_n = 1'b1;
        tick();
        check_vec("t6_nest", 32'(nest_n), 32'd0);
        check_vec("t6_score_hold", 32'(score), 32'd0);
        tick();
        check_vec("t6_score1", 32'(score), 32'd1);
        check_vec("t6_nest_end", 32'(nest_n), 32'd1);
        check_vec("t6_respawn", 32'(frog_reset_n), 32'd0);
        tick();
        check_vec("t6_row0", 32'(row), 32'd0);

        // T6b: overlap at the nest row is a collision only
        repeat (6) press_up();
        up_n = 1'b0;
        tick();
        up_n = 1'b1;
        obst = 8'h10;
        tick();
        check_vec("t6b_collision", 32'(collision_n), 32'd0);
        check_vec("t6b_no_nest", 32'(nest_n), 32'd1);
        obst = 8'h00;
        tick();
        check_vec("t6b_score", 32'(score), 32'd1);
        check_vec("t6b_lives", 32'(lives), 32'd2);
        tick();

        // Score saturates at all-ones
        repeat (15) begin
            repeat (7) press_up();
            tick();
            tick();
        end
        check_vec("t6c_score_sat", 32'(score), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
